ruler_controller: RTL
=====================

# ruler_controller

Sequencer at the head of the mark chain in the Golomb ruler search. It owns the search state that the individual mark counters only react to: which level is enabled, the start value and limit each level sees, and the accumulated distance set handed down the chain. It collects each counter's verdict (next level, next start value, new distances), records every complete ruler found, tightens the length limit, and signals completion when control climbs back to level 0.

## Interface
- NUMPOSITIONS, default `NUMPOSITIONS: number of non-zero marks; levels 1..NUMPOSITIONS.
- PBITS, default `PositionNumberBitMax+1: level-number width.
- VBITS, default `PositionValueBitMax+1: position-value width.
- MAXVALUE, default `MAXVALUE: distance-vector length.
- TIMEOUT, default 255: maximum cycles in WAIT before the block aborts.
- clock  in  1  system clock. One clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a search from IDLE.
- init_limit  in  VBITS  initial exclusive length bound.
- level_ready  in  NUMPOSITIONS  ready flag of counters 1..N.
- marks_val  in  N*VBITS  current val of each counter, flattened with level 1 in the MSBs.
- next_enabled_in  in  N*PBITS  nextEnabled of each counter, flattened.
- next_start_in  in  N*VBITS  nextStartValue of each counter, flattened.
- pd_hash_in  in  N*MAXVALUE  pdHash of each counter, flattened.
- enabled  out  PBITS  active level; 0 means none.
- globalready  out  1  step strobe to the active counter.
- startvalue  out  VBITS  first value the active level tries.
- limit  out  VBITS  current exclusive bound.
- distances  out  [1:MAXVALUE]  OR of the committed hashes of levels 1..enabled-1.
- best_marks  out  N*VBITS  most recent complete ruler.
- found  out  1  one-cycle pulse per complete ruler.
- busy  out  1  high from start until DONE.
- done  out  1  level; set on normal termination or on abort.
- error  out  1  level; set on timeout or on an illegal next_enabled value.

## Operation
- States: IDLE, ISSUE, WAIT, EVAL, FOUND, DONE.
- IDLE:
  - On start: limit <= init_limit, enabled <= 1, startvalue <= 1, all committed hashes cleared, busy <= 1, go to ISSUE.
- ISSUE:
  - Requires level_ready[enabled]=1.
  - Drive globalready=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold globalready=0 for 2 cycles. This is the counter's register latency plus settle time.
  - Then capture the selected level's next_enabled, next_start and pd_hash, and go to EVAL.
  - The wait counter increments each WAIT cycle. Reaching TIMEOUT sets error and goes to DONE.
- EVAL, with L = enabled and n = captured next_enabled:
  - n==L+1 and L<N: committed[L] <= pd_hash; enabled <= L+1; startvalue <= captured next_start; go to ISSUE.
  - n==L+1 and L==N: the ruler is complete; go to FOUND.
  - n==L: clash. Nothing is committed; enabled is unchanged; go to ISSUE.
  - n==L-1 and n>0: committed[L-1] and committed[L] cleared; enabled <= n; go to ISSUE.
  - n==0: go to DONE.
  - Any other n: set error and go to DONE.
- FOUND:
  - best_marks <= marks_val; limit <= val of level N; found pulses.
  - Re-enable level N (its next step exceeds the new limit and climbs); go to ISSUE.
- DONE:
  - busy=0, done=1. The block stays here until reset.
- distances is recomputed combinationally from the committed registers and the current enabled value. committed[k] bits beyond MAXVALUE are ignored.
- Widths: level arithmetic is PBITS wide; L+1 on L==N is never used as an index.

## Timing
- Reset values: enabled=0, globalready=0, startvalue=0, limit=0, distances=0, best_marks=0, found=0, busy=0, done=0, error=0, state IDLE.
- Reset asserted mid-search returns the block to IDLE asynchronously; no partial ruler is kept.
- One step is 4 cycles: ISSUE, WAIT, WAIT, EVAL. FOUND adds 1 cycle.
- start is ignored outside IDLE.
- A level_ready=0 in ISSUE stalls the block without counting toward the timeout.
- limit changes only in FOUND, so it never changes while a counter is being stepped.

## Structure
- The shared definitions file carries NUMPOSITIONS, MAXVALUE, PositionValueBitMax, PositionNumberBitMax and the state encodings.
- One sub-module, distance_accumulator, holds the N committed-hash registers and the masked OR that produces distances.
- The mark_assembly top instantiates ruler_controller beside the counters.

## Test plan
- N=3, init_limit=7, behavioural counter models: found fires with best_marks={1,4,6} and limit=6; the run ends with done=1, error=0, best_marks={1,4,6}.
- A counter returning n=L (clash) 3 times: enabled stays constant and no committed hash changes.
- A counter at L=2 returning n=1: committed[1] and committed[2] are 0, and distances at L=1 is 0.
- A selected counter that never answers: error=1 and done=1 at cycle TIMEOUT+2 after the last ISSUE.
- reset pulsed during WAIT at L=3: all outputs return to their reset values within the same cycle; a following start restarts at enabled=1.
- Injected n=5 with N=3: error=1, done=1.

Source files
------------

// File: rtl/ruler_controller_pkg.sv
// Shared sizing constants and FSM state encoding for the Golomb ruler mark-chain sequencer.
package ruler_controller_pkg;

  localparam int NUMPOSITIONS         = 3;
  localparam int MAXVALUE             = 8;
  localparam int PositionValueBitMax  = 3;
  localparam int PositionNumberBitMax = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EVAL,
    S_FOUND,
    S_DONE
  } state_t;

endpackage

// File: rtl/distance_accumulator.sv
// Per-level committed distance hashes; distances is the OR of levels strictly below enabled.
module distance_accumulator
  import ruler_controller_pkg::*;
#(
  parameter int N  = NUMPOSITIONS,
  parameter int PB = PositionNumberBitMax + 1,
  parameter int M  = MAXVALUE
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear_all,
  input  logic          commit,
  input  logic          drop,
  input  logic [PB-1:0] level,
  input  logic [M:1]    hash,
  input  logic [PB-1:0] enabled,
  output logic [M:1]    distances
);

  logic [M:1] committed [1:N];

  // drop releases both the level being left and the one above it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= N; k++) committed[k] <= '0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (clear_all || (drop && (PB'(k) == level || PB'(k + 1) == level)))
          committed[k] <= '0;
        else if (commit && PB'(k) == level)
          committed[k] <= hash;
      end
    end
  end

  always_comb begin
    distances = '0;
    for (int k = 1; k <= N; k++)
      if (PB'(k) < enabled) distances = distances | committed[k];
  end

endmodule

// File: rtl/ruler_controller.sv
// Head-of-chain sequencer: steps the active mark counter (ISSUE, WAIT x2, EVAL), commits
// distances on advance, records complete rulers and tightens the limit, stops on climb to 0.
module ruler_controller #(
  parameter int NUMPOSITIONS = ruler_controller_pkg::NUMPOSITIONS,
  parameter int PBITS        = ruler_controller_pkg::PositionNumberBitMax + 1,
  parameter int VBITS        = ruler_controller_pkg::PositionValueBitMax + 1,
  parameter int MAXVALUE     = ruler_controller_pkg::MAXVALUE,
  parameter int TIMEOUT      = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [VBITS-1:0]                init_limit,
  input  logic [NUMPOSITIONS:1]           level_ready,
  input  logic [NUMPOSITIONS*VBITS-1:0]   marks_val,
  input  logic [NUMPOSITIONS*PBITS-1:0]   next_enabled_in,
  input  logic [NUMPOSITIONS*VBITS-1:0]   next_start_in,
  input  logic [NUMPOSITIONS*MAXVALUE-1:0] pd_hash_in,
  output logic [PBITS-1:0]                enabled,
  output logic                            globalready,
  output logic [VBITS-1:0]                startvalue,
  output logic [VBITS-1:0]                limit,
  output logic [MAXVALUE:1]               distances,
  output logic [NUMPOSITIONS*VBITS-1:0]   best_marks,
  output logic                            found,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);
  import ruler_controller_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [PBITS-1:0] LAST = PBITS'(NUMPOSITIONS);

  state_t state, state_nxt;
  logic [CW-1:0]       wait_cnt;
  logic [PBITS-1:0]    cap_next, sel_next;
  logic [VBITS-1:0]    cap_start, sel_start, last_val;
  logic [MAXVALUE:1]   cap_hash, sel_hash;
  logic                sel_ready, commit, drop, clear_all, set_err;
  logic                go_up, stay, go_down;

  // Level 1 sits in the MSBs of every flattened bus, so level N is the LSB slice.
  always_comb begin
    sel_ready = 1'b0;
    sel_next  = '0;
    sel_start = '0;
    sel_hash  = '0;
    for (int k = 1; k <= NUMPOSITIONS; k++) begin
      if (enabled == PBITS'(k)) begin
        sel_ready = level_ready[k];
        sel_next  = next_enabled_in[(NUMPOSITIONS-k)*PBITS +: PBITS];
        sel_start = next_start_in[(NUMPOSITIONS-k)*VBITS +: VBITS];
        sel_hash  = pd_hash_in[(NUMPOSITIONS-k)*MAXVALUE +: MAXVALUE];
      end
    end
  end

  assign last_val = marks_val[VBITS-1:0];
  assign go_up    = (cap_next == enabled + PBITS'(1));
  assign stay     = (cap_next == enabled);
  assign go_down  = (cap_next != '0) && (cap_next == enabled - PBITS'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    globalready = 1'b0;
    found       = 1'b0;
    commit      = 1'b0;
    drop        = 1'b0;
    clear_all   = 1'b0;
    set_err     = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        clear_all = 1'b1;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: if (sel_ready) begin
        globalready = 1'b1;
        state_nxt   = S_WAIT;
      end
      // The first WAIT cycle is always spent; only the counter's answer ends the second.
      S_WAIT: begin
        if (wait_cnt != '0 && sel_ready) state_nxt = S_EVAL;
        else if (wait_cnt == CW'(TIMEOUT)) begin
          set_err   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_EVAL: begin
        if (cap_next == '0) state_nxt = S_DONE;
        else if (go_up) begin
          if (enabled == LAST) state_nxt = S_FOUND;
          else begin
            commit    = 1'b1;
            state_nxt = S_ISSUE;
          end
        end else if (stay) state_nxt = S_ISSUE;
        else if (go_down) begin
          drop      = 1'b1;
          state_nxt = S_ISSUE;
        end else begin
          set_err   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_FOUND: begin
        found     = 1'b1;
        state_nxt = S_ISSUE;
      end
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt   <= '0;
      cap_next   <= '0;
      cap_start  <= '0;
      cap_hash   <= '0;
      enabled    <= '0;
      startvalue <= '0;
      limit      <= '0;
      best_marks <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + CW'(1) : '0;
      if (state == S_WAIT) begin
        cap_next  <= sel_next;
        cap_start <= sel_start;
        cap_hash  <= sel_hash;
      end
      if (state == S_IDLE && start) begin
        limit      <= init_limit;
        enabled    <= PBITS'(1);
        startvalue <= VBITS'(1);
        busy       <= 1'b1;
      end
      if (commit) begin
        enabled    <= enabled + PBITS'(1);
        startvalue <= cap_start;
      end
      if (drop) enabled <= cap_next;
      if (found) begin
        best_marks <= marks_val;
        limit      <= last_val;
      end
      if (state != S_DONE && state_nxt == S_DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (set_err) error <= 1'b1;
    end
  end

  distance_accumulator #(
    .N (NUMPOSITIONS),
    .PB(PBITS),
    .M (MAXVALUE)
  ) u_acc (
    .clock    (clock),
    .reset    (reset),
    .clear_all(clear_all),
    .commit   (commit),
    .drop     (drop),
    .level    (enabled),
    .hash     (cap_hash),
    .enabled  (enabled),
    .distances(distances)
  );

endmodule
